// File: rtl/ysyx_25040129_axi_rd_responder_pkg.sv
// Shared AXI read-responder definitions.
// Contents: the AXI burst-type and response codes, plus a helper that tells
//           whether a WRAP burst length is one AXI allows (2, 4, 8 or 16 beats).
package ysyx_25040129_axi_rd_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_25040129_axi_rd_responder_if.sv
// AXI4 read address / read data channel bundle.
// master: drives araddr/arvalid/arlen/arburst and rready.
// slave : drives arready and rdata/rresp/rvalid/rlast.
interface ysyx_25040129_axi_rd_responder_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rlast;

  modport master (
    output araddr, arvalid, arlen, arburst, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  araddr, arvalid, arlen, arburst, rready,
    output arready, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/ysyx_25040129_axi_burst_addr.sv
// Combinational AXI burst address step.
// Inputs : cur (current beat byte address), len (arlen), burst (arburst).
// Outputs: next_addr (address of the following beat),
//          burst_err (reserved burst type, or WRAP with an illegal length).
module ysyx_25040129_axi_burst_addr
  import ysyx_25040129_axi_rd_responder_pkg::*;
(
  input  logic [31:0] cur,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        burst_err
);

  logic [31:0] inc_addr;
  logic [31:0] wrap_mask;

  assign inc_addr  = cur + 32'd4;
  // Legal wrap lengths are 2^n-1, so the window mask is just len with the byte bits appended.
  assign wrap_mask = {26'd0, len[3:0], 2'b11};

  always_comb begin
    next_addr = cur;
    burst_err = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = cur;
      BURST_INCR:  next_addr = inc_addr;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) begin
          next_addr = (cur & ~wrap_mask) | (inc_addr & wrap_mask);
        end else begin
          next_addr = inc_addr;
          burst_err = 1'b1;
        end
      end
      default: burst_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_25040129_axi_rd_responder.sv
// AXI4 read responder in front of a 1-cycle synchronous SRAM/ROM.
// Ports: clk, rst (synchronous, active low), axi (read channels, slave side),
//        mem_en/mem_addr (read strobe and word address), mem_rdata (data the cycle after mem_en).
// Optional build macro YSYX_25040129_RD_DELAY_EN: an LFSR inserts 0..7 idle cycles
// in a DELAY state before each FETCH to stress initiator handshakes.
//
// state | meaning
// IDLE  | arready high, waiting for a read request
// DELAY | optional random idle cycles before a fetch
// FETCH | memory strobe for the current beat (suppressed on error beats)
// CAPT  | register memory data and beat response
// RESP  | rvalid high, hold the beat until rready
module ysyx_25040129_axi_rd_responder
  import ysyx_25040129_axi_rd_responder_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          ADDR_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_25040129_axi_rd_responder_if.slave axi,
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [31:0]                  mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;

  logic [2:0]  state;
  logic [2:0]  pre_fetch;
  logic [31:0] cur;
  logic [7:0]  len;
  logic [1:0]  burst;
  logic [7:0]  beat_cnt;
  logic [1:0]  beat_resp;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic        ar_hs;
  logic        r_hs;
  logic [31:0] next_addr;
  logic        burst_err;
  logic [30:0] off_w;
  logic        in_range;
  logic [1:0]  fetch_resp;

  // arready is gated by rst so it reads 0 while reset is held.
  assign axi.arready = rst && (state == S_IDLE);
  assign axi.rvalid  = (state == S_RESP);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;

  assign ar_hs = axi.arvalid && axi.arready;
  assign r_hs  = axi.rvalid && axi.rready;

  ysyx_25040129_axi_burst_addr u_burst_addr (
    .cur       (cur),
    .len       (len),
    .burst     (burst),
    .next_addr (next_addr),
    .burst_err (burst_err)
  );

  // Word offset from BASE; one spare bit so addresses below BASE come out negative.
  assign off_w    = {1'b0, cur[31:2]} - {1'b0, BASE[31:2]};
  assign in_range = (off_w[30:ADDR_W] == '0);
  assign mem_addr = off_w[ADDR_W-1:0];

  always_comb begin
    fetch_resp = RESP_OKAY;
    if (burst_err) begin
      fetch_resp = RESP_SLVERR;
    end else if (!in_range) begin
      fetch_resp = RESP_DECERR;
    end
  end

  assign mem_en = (state == S_FETCH) && (fetch_resp == RESP_OKAY);

`ifdef YSYX_25040129_RD_DELAY_EN
  localparam logic [2:0] S_DELAY = 3'd4;
  logic [15:0] lfsr;
  logic [2:0]  dly_cnt;

  assign pre_fetch = (lfsr[2:0] != 3'd0) ? S_DELAY : S_FETCH;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr    <= 16'hACE1;
      dly_cnt <= 3'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (ar_hs || (r_hs && !rlast_q)) begin
        dly_cnt <= lfsr[2:0] - 3'd1;
      end else if ((state == S_DELAY) && (dly_cnt != 3'd0)) begin
        dly_cnt <= dly_cnt - 3'd1;
      end
    end
  end
`else
  assign pre_fetch = S_FETCH;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cur       <= 32'd0;
      len       <= 8'd0;
      burst     <= 2'd0;
      beat_cnt  <= 8'd0;
      beat_resp <= 2'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'd0;
      rlast_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ar_hs) begin
            cur      <= axi.araddr;
            len      <= axi.arlen;
            burst    <= axi.arburst;
            beat_cnt <= 8'd0;
            state    <= pre_fetch;
          end
        end
`ifdef YSYX_25040129_RD_DELAY_EN
        S_DELAY: begin
          if (dly_cnt == 3'd0) state <= S_FETCH;
        end
`endif
        S_FETCH: begin
          beat_resp <= fetch_resp;
          state     <= S_CAPT;
        end
        S_CAPT: begin
          rdata_q <= (beat_resp == RESP_OKAY) ? mem_rdata : 32'd0;
          rresp_q <= beat_resp;
          rlast_q <= (beat_cnt == len);
          state   <= S_RESP;
        end
        S_RESP: begin
          if (r_hs) begin
            if (rlast_q) begin
              rlast_q <= 1'b0;
              state   <= S_IDLE;
            end else begin
              cur      <= next_addr;
              beat_cnt <= beat_cnt + 8'd1;
              state    <= pre_fetch;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_axi_rd_responder.sv
// Self-checking bench for ysyx_25040129_axi_rd_responder (default build, no delay macro).
module tb_ysyx_25040129_axi_rd_responder;
  import ysyx_25040129_axi_rd_responder_pkg::*;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  ysyx_25040129_axi_rd_responder_if axi();

  ysyx_25040129_axi_rd_responder #(.BASE(BASE), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int mem_en_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'd4) return 32'hDEAD_BEEF;
    return {a ^ 16'h5A5A, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      mem_rdata  <= mem_word(mem_addr);
      mem_en_cnt <= mem_en_cnt + 1;
    end
  end

  task automatic model_push(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, output int n_ok);
    logic [31:0] a;
    logic [31:0] size;
    bit bad_burst;
    beat_t b;
    a = addr;
    n_ok = 0;
    bad_burst = (burst == 2'b11) ||
                ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    size = (32'(len) + 32'd1) * 32'd4;
    for (int i = 0; i <= int'(len); i++) begin
      if (bad_burst) begin
        b.resp = 2'b10; b.data = 32'd0;
      end else if (a < BASE || a >= 32'h8004_0000) begin
        b.resp = 2'b11; b.data = 32'd0;
      end else begin
        b.resp = 2'b00; b.data = mem_word(16'((a - BASE) >> 2)); n_ok++;
      end
      b.last = (i == int'(len));
      sb.push_back(b);
      case (burst)
        2'b00: a = a;
        2'b10: a = (a / size) * size + ((a % size) + 32'd4) % size;
        default: a = a + 32'd4;
      endcase
    end
  endtask

  task automatic do_burst(input string name, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat, input int stall_cycles,
                          input int abort_beat);
    int n_ok, cnt0, beat, wait_cnt, stall_left, cyc, last_hs, n;
    bit seen;
    beat_t e, held, got;
    model_push(addr, len, burst, n_ok);
    cnt0 = mem_en_cnt;
    axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arvalid = 1'b1; axi.rready = 1'b0;
    n = 0;
    while (axi.arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (axi.arready !== 1'b1) begin
      n_fail++; $display("FAIL %s ar_timeout arready=%b required=1", name, axi.arready);
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    beat = 0; wait_cnt = 0; stall_left = stall_cycles; cyc = 1; last_hs = 0; seen = 0;
    held = '0;
    while (sb.size() > 0 && wait_cnt < 40) begin
      n_checks++;
      if (axi.arready !== 1'b0) begin
        n_fail++; $display("FAIL %s arready_busy got=%b required=0", name, axi.arready);
      end
      if (axi.rvalid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          n_checks++;
          if (cyc - last_hs != 3) begin
            n_fail++; $display("FAIL %s latency beat=%0d got=%0d required=3", name, beat, cyc - last_hs);
          end
        end
        if (beat == abort_beat) return;
        got = {axi.rdata, axi.rresp, axi.rlast};
        if (beat == stall_beat && stall_left > 0) begin
          if (stall_left == stall_cycles) held = got;
          else begin
            n_checks++;
            if (got !== held) begin
              n_fail++; $display("FAIL %s hold got=%h required=%h", name, got, held);
            end
          end
          n_checks++;
          if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL %s stall_mem_en got=%b required=0", name, mem_en);
          end
          axi.rready = 1'b0;
          stall_left--;
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (got !== e) begin
            n_fail++;
            $display("FAIL %s beat=%0d got data=%h resp=%b last=%b required data=%h resp=%b last=%b",
                     name, beat, axi.rdata, axi.rresp, axi.rlast, e.data, e.resp, e.last);
          end
          axi.rready = 1'b1; beat++; last_hs = cyc; seen = 0; wait_cnt = 0;
        end
      end else begin
        axi.rready = 1'b0;
        wait_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    axi.rready = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL %s beat_timeout pending=%0d required=0", name, sb.size());
    end
    sb.delete();
    n_checks++;
    if (mem_en_cnt - cnt0 != n_ok) begin
      n_fail++; $display("FAIL %s mem_en_count got=%0d required=%0d", name, mem_en_cnt - cnt0, n_ok);
    end
    n_checks++;
    if (axi.arready !== 1'b1 || axi.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_after arready=%b rvalid=%b required 1/0", name, axi.arready, axi.rvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    axi.arvalid = 1'b0; axi.rready = 1'b0; axi.araddr = 32'd0; axi.arlen = 8'd0; axi.arburst = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (axi.arready !== 1'b0 || axi.rvalid !== 1'b0 || axi.rlast !== 1'b0 ||
        axi.rresp !== 2'b00 || axi.rdata !== 32'd0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h mem_en=%b required all 0",
               axi.arready, axi.rvalid, axi.rlast, axi.rresp, axi.rdata, mem_en);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (axi.arready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release arready=%b required=1", axi.arready);
    end
  endtask

  task automatic test_single();
    do_burst("single", 32'h8000_0010, 8'd0, BURST_INCR, -1, 0, -1);
  endtask

  task automatic test_incr();
    do_burst("incr4", 32'h8000_0010, 8'd3, BURST_INCR, -1, 0, -1);
    do_burst("fixed3", 32'h8000_0008, 8'd2, BURST_FIXED, -1, 0, -1);
  endtask

  task automatic test_wrap();
    do_burst("wrap4", 32'h8000_000C, 8'd3, BURST_WRAP, -1, 0, -1);
    do_burst("wrap8", 32'h8000_0034, 8'd7, BURST_WRAP, -1, 0, -1);
    do_burst("wrap_bad_len", 32'h8000_0010, 8'd2, BURST_WRAP, -1, 0, -1);
  endtask

  task automatic test_backpressure();
    do_burst("stall", 32'h8000_0100, 8'd1, BURST_INCR, 0, 5, -1);
  endtask

  task automatic test_errors();
    do_burst("decerr_low", 32'h0000_0100, 8'd1, BURST_INCR, -1, 0, -1);
    do_burst("rsvd_burst", 32'h8000_0000, 8'd2, BURST_RSVD, -1, 0, -1);
    do_burst("cross_top", 32'h8003_FFF8, 8'd3, BURST_INCR, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    do_burst("b2b_a", 32'h8000_0200, 8'd1, BURST_INCR, -1, 0, -1);
    do_burst("b2b_b", 32'h8000_0010, 8'd0, BURST_INCR, -1, 0, -1);
  endtask

  task automatic test_reset_mid_burst();
    do_burst("mid_rst", 32'h8000_0040, 8'd7, BURST_INCR, -1, 0, 2);
    n_checks++;
    if (axi.rvalid !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_pre rvalid=%b required=1", axi.rvalid);
    end
    rst = 1'b0;
    axi.rready = 1'b0;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (axi.rvalid !== 1'b0 || axi.arready !== 1'b0 || mem_en !== 1'b0 || axi.rlast !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_in_reset rvalid=%b arready=%b mem_en=%b rlast=%b required all 0",
               axi.rvalid, axi.arready, mem_en, axi.rlast);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (axi.arready !== 1'b1 || axi.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_release arready=%b rvalid=%b required 1/0", axi.arready, axi.rvalid);
    end
    do_burst("after_rst", 32'h8000_0020, 8'd1, BURST_INCR, -1, 0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_wrap();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
